// File: rtl/rsa_modexp.sv
// Modular exponentiation X^E mod M by left-to-right square-and-multiply,
// sequencing a single Montgomery multiplier (MM(a,b) = a*b*2^-MM_W mod M).

module montgomery #(
    parameter int unsigned MM_W = 1024
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [MM_W-1:0] in_a,
    input  logic [MM_W-1:0] in_b,
    input  logic [MM_W-1:0] in_m,
    output logic [MM_W-1:0] result,
    output logic            done
);
    localparam int unsigned STEP  = 64;
    localparam int unsigned STEPS = MM_W / STEP;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned TW    = MM_W + 2;

    logic [TW-1:0]   t;
    logic [TW-1:0]   t_nxt;
    logic [TW-1:0]   t_red;
    logic [MM_W-1:0] a_sh;
    logic [CW-1:0]   cnt;
    logic            run;

    // Radix-2 reduction, STEP bits of a per cycle; t stays below 2M.
    always_comb begin
        t_nxt = t;
        for (int j = 0; j < STEP; j++) begin
            if (a_sh[j]) t_nxt = t_nxt + TW'(in_b);
            if (t_nxt[0]) t_nxt = t_nxt + TW'(in_m);
            t_nxt = t_nxt >> 1;
        end
        t_red = (t_nxt >= TW'(in_m)) ? t_nxt - TW'(in_m) : t_nxt;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            t      <= '0;
            a_sh   <= '0;
            cnt    <= '0;
            run    <= 1'b0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !run) begin
                run  <= 1'b1;
                t    <= '0;
                a_sh <= in_a;
                cnt  <= '0;
            end else if (run) begin
                t    <= t_nxt;
                a_sh <= a_sh >> STEP;
                cnt  <= cnt + CW'(1);
                if (cnt == CW'(STEPS - 1)) begin
                    run    <= 1'b0;
                    done   <= 1'b1;
                    result <= MM_W'(t_red);
                end
            end
        end
    end
endmodule

module rsa_modexp #(
    parameter int unsigned MM_W = 1024
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [MM_W-1:0]         in_x,
    input  logic [MM_W-1:0]         in_e,
    input  logic [$clog2(MM_W):0]   in_e_len,
    input  logic [MM_W-1:0]         in_m,
    input  logic [MM_W-1:0]         in_r,
    input  logic [MM_W-1:0]         in_r2,
    output logic [MM_W-1:0]         result,
    output logic                    done,
    output logic                    busy
);
    localparam int unsigned IW = $clog2(MM_W) + 1;

    typedef enum logic [2:0] {IDLE, LOAD, MM_GO, MM_WAIT, DONE} state_t;
    typedef enum logic [1:0] {TO_MONT, SQUARE, MULT, FROM_MONT} op_t;

    state_t          state;
    op_t             op;
    logic [MM_W-1:0] x_q, e_q, m_q, r_q, r2_q, xm_q, acc_q;
    logic [IW-1:0]   e_len_q;
    logic [IW-1:0]   idx;
    logic [MM_W-1:0] mm_a, mm_b, mm_result;
    logic            mm_start, mm_done;
    logic [IW-1:0]   idx_dec;
    op_t             op_adv;

    assign mm_start = (state == MM_GO);

    // Operands come straight from registers, so they hold for the whole call.
    always_comb begin
        mm_a = acc_q;
        mm_b = acc_q;
        case (op)
            TO_MONT:   begin mm_a = x_q; mm_b = r2_q; end
            SQUARE:    ;
            MULT:      mm_b = xm_q;
            FROM_MONT: mm_b = MM_W'(1);
            default:   ;
        endcase
    end

    // Termination is decided on the pre-decrement index so idx never wraps.
    assign idx_dec = (idx != '0) ? idx - IW'(1) : idx;
    assign op_adv  = (idx != '0) ? SQUARE : FROM_MONT;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            op      <= TO_MONT;
            x_q     <= '0;
            e_q     <= '0;
            m_q     <= '0;
            r_q     <= '0;
            r2_q    <= '0;
            xm_q    <= '0;
            acc_q   <= '0;
            e_len_q <= '0;
            idx     <= '0;
            result  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= LOAD;
                    busy  <= 1'b1;
                end
                LOAD: begin
                    x_q     <= in_x;
                    e_q     <= in_e;
                    e_len_q <= in_e_len;
                    m_q     <= in_m;
                    r_q     <= in_r;
                    r2_q    <= in_r2;
                    op      <= TO_MONT;
                    state   <= MM_GO;
                end
                MM_GO: state <= MM_WAIT;
                MM_WAIT: if (mm_done) begin
                    state <= MM_GO;
                    case (op)
                        TO_MONT: begin
                            xm_q  <= mm_result;
                            acc_q <= r_q;
                            idx   <= (e_len_q != '0) ? e_len_q - IW'(1) : '0;
                            op    <= (e_len_q != '0) ? SQUARE : FROM_MONT;
                        end
                        SQUARE: begin
                            acc_q <= mm_result;
                            if (e_q[idx[IW-2:0]]) begin
                                op <= MULT;
                            end else begin
                                idx <= idx_dec;
                                op  <= op_adv;
                            end
                        end
                        MULT: begin
                            acc_q <= mm_result;
                            idx   <= idx_dec;
                            op    <= op_adv;
                        end
                        FROM_MONT: begin
                            result <= mm_result;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                        default: state <= IDLE;
                    endcase
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    montgomery #(.MM_W(MM_W)) u_mm (
        .clk    (clk),
        .resetn (resetn),
        .start  (mm_start),
        .in_a   (mm_a),
        .in_b   (mm_b),
        .in_m   (m_q),
        .result (mm_result),
        .done   (mm_done)
    );
endmodule
